// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/flow control bundle between the PC sequencer and its environment
interface pc_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_start;
    logic                  i_fetch_ack;
    logic                  i_stall;
    logic                  i_jump_en;
    logic                  i_call_en;
    logic                  i_ret_en;
    logic                  i_halt;
    logic [DATA_WIDTH-1:0] i_jump_addr;
    logic [DATA_WIDTH-1:0] i_pc;
    logic                  o_pc_input_en;
    logic                  o_pc_counter_en;
    logic [DATA_WIDTH-1:0] o_pc_data;
    logic                  o_fetch_req;
    logic                  o_busy;
    logic                  o_stack_err;

    modport master (
        output i_start, i_fetch_ack, i_stall, i_jump_en, i_call_en, i_ret_en, i_halt,
        output i_jump_addr, i_pc,
        input  o_pc_input_en, o_pc_counter_en, o_pc_data, o_fetch_req, o_busy, o_stack_err
    );

    modport slave (
        input  i_start, i_fetch_ack, i_stall, i_jump_en, i_call_en, i_ret_en, i_halt,
        input  i_jump_addr, i_pc,
        output o_pc_input_en, o_pc_counter_en, o_pc_data, o_fetch_req, o_busy, o_stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter fetch/flow sequencer with return-address stack
module pc_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                state;
    logic [SP_W-1:0]       sp;
    logic [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                  stack_err;

    logic                  stack_empty;
    logic                  stack_full;
    logic [IDX_W-1:0]      top_idx;
    logic [IDX_W-1:0]      push_idx;
    logic [SP_W-1:0]       sp_minus_one;

    logic                  pc_input_en;
    logic                  pc_counter_en;
    logic [DATA_WIDTH-1:0] pc_data;
    logic                  do_push;
    logic                  do_pop;
    logic                  err_set;
    logic                  leave_exec;

    assign stack_empty  = (sp == '0);
    assign stack_full   = (sp == SP_W'(STACK_DEPTH));
    assign sp_minus_one = sp - SP_W'(1);
    assign top_idx      = sp_minus_one[IDX_W-1:0];
    assign push_idx     = sp[IDX_W-1:0];

    // EXEC decision: only the highest-priority event acts, everything is zero outside EXEC
    always_comb begin
        pc_input_en   = 1'b0;
        pc_counter_en = 1'b0;
        pc_data       = '0;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        err_set       = 1'b0;
        leave_exec    = 1'b0;
        if (state == S_EXEC) begin
            if (bus.i_halt) begin
                leave_exec = 1'b0;
            end else if (bus.i_ret_en) begin
                leave_exec = 1'b1;
                if (!stack_empty) begin
                    pc_input_en = 1'b1;
                    pc_data     = stack_mem[top_idx];
                    do_pop      = 1'b1;
                end else begin
                    err_set       = 1'b1;
                    pc_counter_en = 1'b1;
                end
            end else if (bus.i_call_en) begin
                leave_exec = 1'b1;
                if (!stack_full) begin
                    do_push     = 1'b1;
                    pc_input_en = 1'b1;
                    pc_data     = bus.i_jump_addr;
                end else begin
                    err_set       = 1'b1;
                    pc_counter_en = 1'b1;
                end
            end else if (bus.i_jump_en) begin
                leave_exec  = 1'b1;
                pc_input_en = 1'b1;
                pc_data     = bus.i_jump_addr;
            end else if (bus.i_stall) begin
                leave_exec = 1'b0;
            end else begin
                leave_exec    = 1'b1;
                pc_counter_en = 1'b1;
            end
        end
    end

    // State machine, return stack and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sp        <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (bus.i_start) state <= S_REQ;
                S_REQ:  if (bus.i_fetch_ack) state <= S_EXEC;
                S_EXEC: begin
                    if (bus.i_halt) begin
                        state <= S_HALT;
                    end else if (leave_exec) begin
                        state <= S_REQ;
                    end
                end
                S_HALT: if (bus.i_start) state <= S_REQ;
                default: state <= S_IDLE;
            endcase
            if (do_push) begin
                stack_mem[push_idx] <= bus.i_pc + DATA_WIDTH'(1);
                sp                  <= sp + SP_W'(1);
            end else if (do_pop) begin
                sp <= sp_minus_one;
            end
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

    assign bus.o_pc_input_en   = pc_input_en;
    assign bus.o_pc_counter_en = pc_counter_en;
    assign bus.o_pc_data       = pc_data;
    assign bus.o_fetch_req     = (state == S_REQ);
    assign bus.o_busy          = (state == S_REQ) || (state == S_EXEC);
    assign bus.o_stack_err     = stack_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    logic clk;
    logic rst;

    pc_sequencer_if #(.DATA_WIDTH(8)) bus ();

    pc_sequencer #(.DATA_WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       ld;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic [7:0] pc_model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The program counter the sequencer drives, fed back on i_pc
    always @(posedge clk) begin
        if (rst) pc_model <= 8'h00;
        else if (bus.o_pc_input_en) pc_model <= bus.o_pc_data;
        else if (bus.o_pc_counter_en) pc_model <= pc_model + 8'h01;
    end
    assign bus.i_pc = pc_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT asserts a PC enable, pop and compare
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_pc_input_en || bus.o_pc_counter_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: input_en=%0b counter_en=%0b data=%0h with nothing expected",
                             bus.o_pc_input_en, bus.o_pc_counter_en, bus.o_pc_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.o_pc_input_en !== e.ld || bus.o_pc_counter_en !== !e.ld ||
                        bus.o_pc_data !== (e.ld ? e.data : 8'h00)) begin
                        errors++;
                        $display("FAIL %s: got input_en=%0b counter_en=%0b data=%0h expected input_en=%0b data=%0h",
                                 e.name, bus.o_pc_input_en, bus.o_pc_counter_en, bus.o_pc_data,
                                 e.ld, e.ld ? e.data : 8'h00);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_start     = 1'b0;
        bus.i_fetch_ack = 1'b0;
        bus.i_stall     = 1'b0;
        bus.i_jump_en   = 1'b0;
        bus.i_call_en   = 1'b0;
        bus.i_ret_en    = 1'b0;
        bus.i_halt      = 1'b0;
        bus.i_jump_addr = 8'h00;
    endtask

    task automatic expect_ev(input logic ld, input logic [7:0] data, input string name);
        exp_t e;
        e.ld   = ld;
        e.data = data;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    // Hold REQ for delay cycles without ack, then ack; returns positioned in EXEC
    task automatic fetch(input logic [7:0] exp_pc, input int delay);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("req_wait_fetch_req", bus.o_fetch_req, 1);
            step();
        end
        bus.i_fetch_ack = 1'b1;
        @(negedge clk);
        chk("fetch_req", bus.o_fetch_req, 1);
        chk("fetch_pc", bus.i_pc, exp_pc);
        step();
        bus.i_fetch_ack = 1'b0;
    endtask

    task automatic exec(input logic halt, input logic ret, input logic call, input logic jump,
                        input logic stall, input logic [7:0] addr);
        bus.i_halt      = halt;
        bus.i_ret_en    = ret;
        bus.i_call_en   = call;
        bus.i_jump_en   = jump;
        bus.i_stall     = stall;
        bus.i_jump_addr = addr;
        @(negedge clk);
        chk("exec_busy", bus.o_busy, 1);
        chk("exec_fetch_req", bus.o_fetch_req, 0);
        step();
        clear_in();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_fetch_req"}, bus.o_fetch_req, 0);
        chk({name, "_busy"}, bus.o_busy, 0);
        chk({name, "_input_en"}, bus.o_pc_input_en, 0);
        chk({name, "_counter_en"}, bus.o_pc_counter_en, 0);
        chk({name, "_data"}, bus.o_pc_data, 0);
        chk({name, "_stack_err"}, bus.o_stack_err, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_in();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("idle_busy", bus.o_busy, 0);
        @(posedge clk);
        #1;

        // T1: straight-line fetch 0x00..0x03
        start();
        for (int i = 0; i < 4; i++) begin
            expect_ev(1'b0, 8'h00, "t1_increment");
            fetch(8'(i), 0);
            exec(0, 0, 0, 0, 0, 8'h00);
        end

        // T2: call/return, then a call from 0xFF whose return wraps to 0x00
        expect_ev(1'b1, 8'h10, "t2_jump_10");
        fetch(8'h04, 0);
        exec(0, 0, 0, 1, 0, 8'h10);
        expect_ev(1'b1, 8'h40, "t2_call_40");
        fetch(8'h10, 0);
        exec(0, 0, 1, 0, 0, 8'h40);
        expect_ev(1'b0, 8'h00, "t2_inc_40");
        fetch(8'h40, 0);
        exec(0, 0, 0, 0, 0, 8'h00);
        expect_ev(1'b0, 8'h00, "t2_inc_41");
        fetch(8'h41, 0);
        exec(0, 0, 0, 0, 0, 8'h00);
        expect_ev(1'b1, 8'h11, "t2_ret_11");
        fetch(8'h42, 0);
        exec(0, 1, 0, 0, 0, 8'h00);
        expect_ev(1'b1, 8'hFF, "t2_jump_ff");
        fetch(8'h11, 0);
        exec(0, 0, 0, 1, 0, 8'hFF);
        expect_ev(1'b1, 8'h05, "t2_call_from_ff");
        fetch(8'hFF, 0);
        exec(0, 0, 1, 0, 0, 8'h05);
        expect_ev(1'b1, 8'h00, "t2_ret_wrap_00");
        fetch(8'h05, 0);
        exec(0, 1, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("t2_no_err", bus.o_stack_err, 0);

        // T3: four nested calls fit, fifth overflows; four returns restore, fifth underflows
        @(posedge clk);
        #1;
        expect_ev(1'b1, 8'h20, "t3_jump_20");
        fetch(8'h00, 0);
        exec(0, 0, 0, 1, 0, 8'h20);
        for (int k = 0; k < 4; k++) begin
            expect_ev(1'b1, 8'(8'h30 + 16 * k), "t3_call");
            fetch(8'(8'h20 + 16 * k), 0);
            exec(0, 0, 1, 0, 0, 8'(8'h30 + 16 * k));
        end
        @(negedge clk);
        chk("t3_err_before_overflow", bus.o_stack_err, 0);
        @(posedge clk);
        #1;
        expect_ev(1'b0, 8'h00, "t3_call_overflow_inc");
        fetch(8'h60, 0);
        exec(0, 0, 1, 0, 0, 8'h70);
        @(negedge clk);
        chk("t3_overflow_err", bus.o_stack_err, 1);
        @(posedge clk);
        #1;
        expect_ev(1'b1, 8'h51, "t3_ret_51");
        fetch(8'h61, 0);
        exec(0, 1, 0, 0, 0, 8'h00);
        expect_ev(1'b1, 8'h41, "t3_ret_41");
        fetch(8'h51, 0);
        exec(0, 1, 0, 0, 0, 8'h00);
        expect_ev(1'b1, 8'h31, "t3_ret_31");
        fetch(8'h41, 0);
        exec(0, 1, 0, 0, 0, 8'h00);
        expect_ev(1'b1, 8'h21, "t3_ret_21");
        fetch(8'h31, 0);
        exec(0, 1, 0, 0, 0, 8'h00);
        expect_ev(1'b0, 8'h00, "t3_ret_underflow_inc");
        fetch(8'h21, 0);
        exec(0, 1, 0, 0, 0, 8'h00);

        // T4: halt outranks jump and stall; resume at same PC; stall holds EXEC
        fetch(8'h22, 0);
        exec(1, 0, 0, 1, 1, 8'h77);
        @(negedge clk);
        chk("t4_halt_busy", bus.o_busy, 0);
        chk("t4_halt_fetch_req", bus.o_fetch_req, 0);
        chk("t4_err_sticky", bus.o_stack_err, 1);
        @(posedge clk);
        #1;
        step();
        @(negedge clk);
        chk("t4_halt_stays", bus.o_busy, 0);
        @(posedge clk);
        #1;
        start();
        fetch(8'h22, 0);
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_busy", bus.o_busy, 1);
            chk("t4_stall_fetch_req", bus.o_fetch_req, 0);
            chk("t4_stall_pc", bus.i_pc, 8'h22);
            step();
        end
        bus.i_stall = 1'b0;
        expect_ev(1'b0, 8'h00, "t4_after_stall_inc");
        exec(0, 0, 0, 0, 0, 8'h00);

        // T5: late ack, jump asserted only during REQ is ignored
        bus.i_jump_en   = 1'b1;
        bus.i_jump_addr = 8'h99;
        fetch(8'h23, 4);
        expect_ev(1'b0, 8'h00, "t5_inc_not_jump");
        exec(0, 0, 0, 0, 0, 8'h00);

        // T6: reset during a call in EXEC with two stacked entries
        expect_ev(1'b1, 8'h80, "t6_call_80");
        fetch(8'h24, 0);
        exec(0, 0, 1, 0, 0, 8'h80);
        expect_ev(1'b1, 8'h90, "t6_call_90");
        fetch(8'h80, 0);
        exec(0, 0, 1, 0, 0, 8'h90);
        fetch(8'h90, 0);
        expect_ev(1'b1, 8'hA0, "t6_call_during_rst");
        bus.i_call_en   = 1'b1;
        bus.i_jump_addr = 8'hA0;
        rst             = 1'b1;
        step();
        rst = 1'b0;
        clear_in();
        @(negedge clk);
        chk_all_zero("t6_after_rst");
        @(posedge clk);
        #1;
        start();
        expect_ev(1'b0, 8'h00, "t6_ret_on_empty_inc");
        fetch(8'h00, 0);
        exec(0, 1, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("t6_stack_was_empty", bus.o_stack_err, 1);

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
